// File: rtl/array_alloc_arbiter.sv
// Round-robin arbitrated array allocator: free-array LIFO plus high-water counter; optional ALLOC_ZERO_FILL_EN.
// Latency: ack 2 cycles after the request is seen idle (+NArea cycles for a zero-filled alloc).
// Backpressure: requesters hold req_valid until their ack; one transaction in flight, others wait.
module array_alloc_arbiter #(
    parameter int NReq               = 2,
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 10,
    parameter int NArrays            = 2000,
    parameter int HeapAddrWidth      = 14
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NReq-1:0]                    req_valid,
    input  logic [NReq-1:0]                    req_free,
    input  logic [NReq*MemoryElementWidth-1:0] req_array,
    output logic [NReq-1:0]                    ack,
    output logic [MemoryElementWidth-1:0]      resp_array,
    output logic                               resp_error,
    output logic                               size_we,
    output logic [MemoryElementWidth-1:0]      size_addr,
    output logic [MemoryElementWidth-1:0]      size_data,
    output logic                               heap_we,
    output logic [HeapAddrWidth-1:0]           heap_addr,
    output logic [MemoryElementWidth-1:0]      heap_data,
    output logic [MemoryElementWidth-1:0]      allocs,
    output logic [MemoryElementWidth-1:0]      in_use
);

    localparam int W  = MemoryElementWidth;
    localparam int RW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int TW = $clog2(NArrays + 1);
    localparam int SW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam logic [W:0] N_ARRAYS = (W+1)'(NArrays);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [RW-1:0] rr;
    logic [RW-1:0] grant;
    logic          op_free;
    logic [W-1:0]  op_array;
    logic [W-1:0]  result;
    logic          error;
    logic [TW-1:0] top;
    logic [W-1:0]  stack [NArrays];

`ifdef ALLOC_ZERO_FILL_EN
    localparam int KW = (NArea > 1) ? $clog2(NArea) : 1;
    logic [KW-1:0] fill_k;
`endif

    // Round-robin scan starting at rr, wrapping at NReq-1.
    logic          scan_hit;
    logic [RW-1:0] scan_idx;
    logic [RW-1:0] scan_ptr;
    logic          scan_free;
    logic [W-1:0]  scan_array;

    always_comb begin
        scan_hit = 1'b0;
        scan_idx = rr;
        scan_ptr = rr;
        for (int i = 0; i < NReq; i++) begin
            if (!scan_hit && req_valid[scan_ptr]) begin
                scan_hit = 1'b1;
                scan_idx = scan_ptr;
            end
            scan_ptr = (scan_ptr == RW'(NReq - 1)) ? '0 : scan_ptr + 1'b1;
        end
        scan_free  = req_free[scan_idx];
        scan_array = '0;
        for (int i = 0; i < NReq; i++) begin
            if (RW'(i) == scan_idx) scan_array = req_array[i*W +: W];
        end
    end

    logic         pop_ok;
    logic         new_ok;
    logic         alloc_ok;
    logic         free_ok;
    logic [W-1:0] alloc_res;

    always_comb begin
        pop_ok    = (top != '0);
        new_ok    = ({1'b0, allocs} < N_ARRAYS);
        alloc_ok  = !op_free && (pop_ok || new_ok);
        free_ok   = op_free && (op_array < allocs);
        alloc_res = pop_ok ? stack[SW'(top - 1'b1)] : allocs;
    end

    // Stack storage needs no reset; only the top pointer defines validity.
    always_ff @(posedge clock) begin
        if (!reset && state == S_EXEC && free_ok) stack[SW'(top)] <= op_array;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            rr       <= '0;
            grant    <= '0;
            op_free  <= 1'b0;
            op_array <= '0;
            result   <= '0;
            error    <= 1'b0;
            top      <= '0;
            allocs   <= '0;
            in_use   <= '0;
`ifdef ALLOC_ZERO_FILL_EN
            fill_k   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (scan_hit) begin
                        grant    <= scan_idx;
                        op_free  <= scan_free;
                        op_array <= scan_array;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef ALLOC_ZERO_FILL_EN
                    fill_k <= '0;
`endif
                    if (op_free) begin
                        result <= op_array;
                        error  <= !free_ok;
                        if (free_ok) begin
                            top    <= top + 1'b1;
                            in_use <= in_use - 1'b1;
                        end
                        state <= S_DONE;
                    end else if (alloc_ok) begin
                        result <= alloc_res;
                        error  <= 1'b0;
                        if (pop_ok) top <= top - 1'b1;
                        else        allocs <= allocs + 1'b1;
                        in_use <= in_use + 1'b1;
`ifdef ALLOC_ZERO_FILL_EN
                        state <= S_CLEAR;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        result <= '0;
                        error  <= 1'b1;
                        state  <= S_DONE;
                    end
                end
`ifdef ALLOC_ZERO_FILL_EN
                S_CLEAR: begin
                    if (fill_k == KW'(NArea - 1)) state <= S_DONE;
                    else                          fill_k <= fill_k + 1'b1;
                end
`endif
                S_DONE: begin
                    rr    <= (grant == RW'(NReq - 1)) ? '0 : grant + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ack        = '0;
        resp_array = '0;
        resp_error = 1'b0;
        if (state == S_DONE) begin
            for (int i = 0; i < NReq; i++) ack[i] = (RW'(i) == grant);
            resp_array = result;
            resp_error = error;
        end
        size_we   = (state == S_EXEC) && alloc_ok;
        size_addr = size_we ? alloc_res : '0;
        size_data = '0;
`ifdef ALLOC_ZERO_FILL_EN
        heap_we   = (state == S_CLEAR);
        heap_addr = heap_we ? HeapAddrWidth'(result) * HeapAddrWidth'(NArea) + HeapAddrWidth'(fill_k) : '0;
`else
        heap_we   = 1'b0;
        heap_addr = '0;
`endif
        heap_data = '0;
    end

endmodule

// File: tb/tb_array_alloc_arbiter.sv
// Bench for array_alloc_arbiter: directed scenarios plus randomized batches against a queue-based allocator model.
module tb_array_alloc_arbiter;

    localparam int NREQ  = 3;
    localparam int W     = 12;
    localparam int NAREA = 10;
    localparam int NARR  = 6;
    localparam int HAW   = 14;
`ifdef ALLOC_ZERO_FILL_EN
    localparam int FILL_CYC = NAREA;
`else
    localparam int FILL_CYC = 0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_free;
    logic [NREQ*W-1:0] req_array;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      resp_array;
    logic              resp_error;
    logic              size_we;
    logic [W-1:0]      size_addr;
    logic [W-1:0]      size_data;
    logic              heap_we;
    logic [HAW-1:0]    heap_addr;
    logic [W-1:0]      heap_data;
    logic [W-1:0]      allocs;
    logic [W-1:0]      in_use;

    array_alloc_arbiter #(
        .NReq(NREQ), .MemoryElementWidth(W), .NArea(NAREA), .NArrays(NARR), .HeapAddrWidth(HAW)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_free(req_free), .req_array(req_array),
        .ack(ack), .resp_array(resp_array), .resp_error(resp_error),
        .size_we(size_we), .size_addr(size_addr), .size_data(size_data),
        .heap_we(heap_we), .heap_addr(heap_addr), .heap_data(heap_data),
        .allocs(allocs), .in_use(in_use)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: LIFO of freed arrays, high-water count, live set, round-robin pointer.
    int m_free[$];
    int m_allocs;
    int m_inuse;
    int m_rr;
    bit m_live[NARR];
    int last_res[NREQ];
    int last_err[NREQ];
    int order[$];

    function automatic logic [NREQ*W-1:0] pack(input int a0, input int a1, input int a2);
        return {W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic model_reset();
        m_free.delete();
        m_allocs = 0;
        m_inuse  = 0;
        m_rr     = 0;
        foreach (m_live[i]) m_live[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_free  = '0;
        req_array = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one batch of simultaneous requests and checks every ack against the model.
    task automatic run_batch(input logic [NREQ-1:0] vmask, input logic [NREQ-1:0] fmask,
                             input logic [NREQ*W-1:0] arrs);
        logic [NREQ-1:0] pend;
        int since, budget, n_size, size_a, g, idx, a, exp_res, exp_err, exp_lat;
        bit first, size_bad, heap_bad, alloc_ok, hok;
        int heap_q[$];
        @(posedge clock);
        @(negedge clock);
        req_free  = fmask;
        req_array = arrs;
        req_valid = vmask;
        pend = vmask;
        order.delete();
        since = 0; budget = 0; n_size = 0; size_a = 0; first = 1'b1;
        size_bad = 1'b0; heap_bad = 1'b0;
        heap_q.delete();
        while (pend != '0 && budget < 200) begin
            @(posedge clock);
            @(negedge clock);
            since++;
            budget++;
            if (size_we) begin
                n_size++;
                size_a = int'(size_addr);
                if (size_data !== '0) size_bad = 1'b1;
            end
            if (heap_we) begin
                heap_q.push_back(int'(heap_addr));
                if (heap_data !== '0) heap_bad = 1'b1;
            end
            if (ack != '0) begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_rr + k) % NREQ;
                    if (g < 0 && pend[idx]) g = idx;
                end
                a = int'(arrs[g*W +: W]);
                alloc_ok = 1'b0;
                if (fmask[g]) begin
                    exp_res = a;
                    if (a >= m_allocs) exp_err = 1;
                    else begin
                        exp_err = 0;
                        m_free.push_back(a);
                        m_inuse--;
                        m_live[a] = 1'b0;
                    end
                end else begin
                    exp_err = 0;
                    if (m_free.size() > 0) begin
                        exp_res = m_free.pop_back();
                        alloc_ok = 1'b1;
                    end else if (m_allocs < NARR) begin
                        exp_res = m_allocs;
                        m_allocs++;
                        alloc_ok = 1'b1;
                    end else begin
                        exp_res = 0;
                        exp_err = 1;
                    end
                    if (alloc_ok) begin
                        m_inuse++;
                        m_live[exp_res] = 1'b1;
                    end
                end
                exp_lat = (first ? 2 : 3) + (alloc_ok ? FILL_CYC : 0);

                tests++;
                if (ack !== NREQ'(1 << g)) begin
                    fails++;
                    $display("FAIL ack_grant: got %b want %b", ack, NREQ'(1 << g));
                end
                tests++;
                if (resp_array !== W'(exp_res) || resp_error !== 1'(exp_err)) begin
                    fails++;
                    $display("FAIL resp: got array %0d err %0b want array %0d err %0d",
                             resp_array, resp_error, exp_res, exp_err);
                end
                tests++;
                if (allocs !== W'(m_allocs) || in_use !== W'(m_inuse)) begin
                    fails++;
                    $display("FAIL counters: got allocs %0d in_use %0d want %0d %0d",
                             allocs, in_use, m_allocs, m_inuse);
                end
                tests++;
                if (since != exp_lat) begin
                    fails++;
                    $display("FAIL latency: got %0d cycles want %0d", since, exp_lat);
                end
                tests++;
                if (alloc_ok ? (n_size != 1 || size_a != exp_res || size_bad) : (n_size != 0)) begin
                    fails++;
                    $display("FAIL size_write: got %0d strobes addr %0d want %0d strobes addr %0d",
                             n_size, size_a, alloc_ok ? 1 : 0, exp_res);
                end
                hok = !heap_bad && (heap_q.size() == ((alloc_ok && FILL_CYC > 0) ? NAREA : 0));
                if (hok) begin
                    foreach (heap_q[k]) if (heap_q[k] != exp_res * NAREA + k) hok = 1'b0;
                end
                tests++;
                if (!hok) begin
                    fails++;
                    $display("FAIL heap_fill: got %0d writes want %0d starting at %0d",
                             heap_q.size(), (alloc_ok && FILL_CYC > 0) ? NAREA : 0, exp_res * NAREA);
                end
                last_res[g] = int'(resp_array);
                last_err[g] = int'(resp_error);
                order.push_back(g);
                m_rr = (g + 1) % NREQ;
                pend[g] = 1'b0;
                req_valid = pend;
                since = 0; n_size = 0; first = 1'b0; size_bad = 1'b0; heap_bad = 1'b0;
                heap_q.delete();
            end else begin
                tests++;
                if (resp_array !== '0 || resp_error !== 1'b0) begin
                    fails++;
                    $display("FAIL resp_idle: got array %0d err %0b want 0 0", resp_array, resp_error);
                end
            end
        end
        if (pend != '0) begin
            tests++;
            fails++;
            $display("FAIL timeout: pending %b after %0d cycles want none", pend, budget);
            req_valid = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_free = '0; req_array = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        tests++;
        if (ack !== '0 || resp_array !== '0 || resp_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_resp: got ack %b array %0d err %0b want 0", ack, resp_array, resp_error);
        end
        tests++;
        if (size_we !== 1'b0 || size_addr !== '0 || size_data !== '0 ||
            heap_we !== 1'b0 || heap_addr !== '0 || heap_data !== '0) begin
            fails++;
            $display("FAIL reset_strobes: got size_we %b heap_we %b want 0", size_we, heap_we);
        end
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        tests++;
        if (allocs !== '0 || in_use !== '0 || ack !== '0) begin
            fails++;
            $display("FAIL reset_counters: got allocs %0d in_use %0d want 0 0", allocs, in_use);
        end
    endtask

    task automatic test_alloc_seq();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_batch(3'b001, 3'b000, '0);
            tests++;
            if (last_res[0] != i || last_err[0] != 0) begin
                fails++;
                $display("FAIL alloc_seq: got %0d err %0d want %0d err 0", last_res[0], last_err[0], i);
            end
        end
        tests++;
        if (allocs !== W'(3) || in_use !== W'(3)) begin
            fails++;
            $display("FAIL alloc_seq_counts: got %0d %0d want 3 3", allocs, in_use);
        end
    endtask

    task automatic test_free_realloc();
        run_batch(3'b001, 3'b001, pack(1, 0, 0));
        tests++;
        if (last_err[0] != 0 || last_res[0] != 1) begin
            fails++;
            $display("FAIL free_ok: got array %0d err %0d want 1 err 0", last_res[0], last_err[0]);
        end
        run_batch(3'b001, 3'b000, '0);
        tests++;
        if (last_res[0] != 1 || allocs !== W'(3) || in_use !== W'(3)) begin
            fails++;
            $display("FAIL realloc: got %0d allocs %0d in_use %0d want 1 3 3", last_res[0], allocs, in_use);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            run_batch(3'b011, 3'b000, '0);
            tests++;
            if (order.size() != 2 || order[0] != 0 || order[1] != 1 ||
                last_res[0] != 2 * r || last_res[1] != 2 * r + 1) begin
                fails++;
                $display("FAIL simultaneous: got req0 %0d req1 %0d want %0d %0d",
                         last_res[0], last_res[1], 2 * r, 2 * r + 1);
            end
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        run_batch(3'b001, 3'b001, pack(0, 0, 0));
        tests++;
        if (last_err[0] != 1) begin
            fails++;
            $display("FAIL free_unallocated: got err %0d want 1", last_err[0]);
        end
        for (int i = 0; i < NARR; i++) run_batch(3'b010, 3'b000, '0);
        run_batch(3'b010, 3'b000, '0);
        tests++;
        if (last_err[1] != 1 || last_res[1] != 0) begin
            fails++;
            $display("FAIL exhausted: got array %0d err %0d want 0 err 1", last_res[1], last_err[1]);
        end
        run_batch(3'b100, 3'b100, pack(0, 0, 7));
        tests++;
        if (last_err[2] != 1 || in_use !== W'(NARR) || allocs !== W'(NARR)) begin
            fails++;
            $display("FAIL free_bad: got err %0d in_use %0d want 1 %0d", last_err[2], in_use, NARR);
        end
    endtask

    task automatic test_reset_mid(input int cycles_in);
        do_reset();
        req_free = '0; req_array = '0; req_valid = 3'b001;
        repeat (cycles_in) @(posedge clock);
        @(negedge clock);
        tests++;
        if (cycles_in == 1 ? (size_we !== 1'b1 || size_addr !== '0)
                           : (heap_we !== 1'b1 || heap_addr !== HAW'(cycles_in - 2))) begin
            fails++;
            $display("FAIL mid_op_strobe: got size_we %b heap_we %b heap_addr %0d want active",
                     size_we, heap_we, heap_addr);
        end
        reset = 1'b1;
        req_valid = '0;
        @(posedge clock);
        @(negedge clock);
        tests++;
        if (ack !== '0 || resp_array !== '0 || resp_error !== 1'b0 || size_we !== 1'b0 ||
            heap_we !== 1'b0 || heap_addr !== '0 || allocs !== '0 || in_use !== '0) begin
            fails++;
            $display("FAIL reset_abort: got ack %b size_we %b heap_we %b allocs %0d want all 0",
                     ack, size_we, heap_we, allocs);
        end
        reset = 1'b0;
        model_reset();
        run_batch(3'b001, 3'b000, '0);
        tests++;
        if (last_res[0] != 0 || last_err[0] != 0) begin
            fails++;
            $display("FAIL after_abort: got %0d err %0d want 0 err 0", last_res[0], last_err[0]);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] vmask, fmask;
        logic [NREQ*W-1:0] arrs;
        bit used[NARR];
        int cand[$];
        int a, pick;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            vmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            fmask = '0;
            arrs  = '0;
            foreach (used[i]) used[i] = 1'b0;
            for (int r = 0; r < NREQ; r++) begin
                if (vmask[r] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 3) == 0) begin
                        fmask[r] = 1'b1;
                        a = NARR + int'($urandom_range(0, 3));
                        arrs[r*W +: W] = W'(a);
                    end else begin
                        cand.delete();
                        for (int k = 0; k < NARR; k++) if (m_live[k] && !used[k]) cand.push_back(k);
                        if (cand.size() > 0) begin
                            pick = cand[$urandom_range(0, cand.size() - 1)];
                            used[pick] = 1'b1;
                            fmask[r] = 1'b1;
                            arrs[r*W +: W] = W'(pick);
                        end
                    end
                end
            end
            run_batch(vmask, fmask, arrs);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_free = '0; req_array = '0;
        test_reset();
        test_alloc_seq();
        test_free_realloc();
        test_simultaneous();
        test_exhaust();
        test_reset_mid(1);
        if (FILL_CYC > 0) test_reset_mid(4);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
